// File: rtl/hpu_cmd_arbiter_pkg.sv
// Width helpers for the command arbiter: outstanding-counter width and the
// core index width.
package hpu_cmd_arb_pkg;
  // Wide enough to hold MAX_OUTSTANDING itself, so the counter never wraps.
  function automatic int cnt_width(input int max_out);
    return $clog2(max_out + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/hpu_cmd_pkg.sv
// Cluster command package: command request and completion types that the
// command frontends, the arbiter and the cluster command unit all share.
package hpu_cmd_pkg;
  localparam int CMD_CORE_ID_W = 16;

  typedef struct packed {
    logic [7:0]               cluster_id;
    logic [CMD_CORE_ID_W-1:0] core_id;
    logic [7:0]               local_cmd_id;
  } cmd_id_t;

  typedef struct packed {
    cmd_id_t     cmd_id;
    logic [31:0] payload;
  } cmd_req_t;

  typedef struct packed {
    cmd_id_t    cmd_id;
    logic [7:0] status;
  } cmd_resp_t;
endpackage

// File: rtl/hpu_cmd_arbiter_if.sv
// Command/completion bus between the per-core frontends, the arbiter and the
// cluster command unit. slave = arbiter side, master = the surrounding cluster.
interface hpu_cmd_arbiter_if #(parameter int NUM_HPUS = 8);
  import hpu_cmd_pkg::*;

  logic [NUM_HPUS-1:0]     hpu_cmd_valid_i;
  logic [NUM_HPUS-1:0]     hpu_cmd_ready_o;
  cmd_req_t [NUM_HPUS-1:0] hpu_cmd_i;
  logic                    cmd_valid_o;
  logic                    cmd_ready_i;
  cmd_req_t                cmd_o;
  logic                    cmd_resp_valid_i;
  cmd_resp_t               cmd_resp_i;
  logic [NUM_HPUS-1:0]     hpu_cmd_resp_valid_o;
  cmd_resp_t               hpu_cmd_resp_o;
  logic                    resp_err_o;
  logic                    idle_o;

  modport slave (
    input  hpu_cmd_valid_i, hpu_cmd_i, cmd_ready_i, cmd_resp_valid_i, cmd_resp_i,
    output hpu_cmd_ready_o, cmd_valid_o, cmd_o, hpu_cmd_resp_valid_o, hpu_cmd_resp_o,
           resp_err_o, idle_o
  );

  modport master (
    output hpu_cmd_valid_i, hpu_cmd_i, cmd_ready_i, cmd_resp_valid_i, cmd_resp_i,
    input  hpu_cmd_ready_o, cmd_valid_o, cmd_o, hpu_cmd_resp_valid_o, hpu_cmd_resp_o,
           resp_err_o, idle_o
  );
endinterface

// File: rtl/hpu_cmd_arbiter_rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around; returns one-hot grant, its index and a valid flag.
module hpu_rr_arb import hpu_cmd_arb_pkg::*; #(
  parameter int N  = 8,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [IW-1:0] j;

  // Walk from the far end back towards ptr_i so the nearest hit wins last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr_i + IW'(k);
      if (req_i[j]) begin
        idx_o = j;
        vld_o = 1'b1;
      end
    end
    if (vld_o) gnt_o[idx_o] = 1'b1;
  end
endmodule

// File: rtl/hpu_cmd_arbiter.sv
// Round-robin command arbiter in front of the cluster command unit, with
// per-core outstanding-command throttling and completion routing by core_id.
module hpu_cmd_arbiter import hpu_cmd_pkg::*, hpu_cmd_arb_pkg::*; #(
  parameter int NUM_HPUS        = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CORE_ID_WIDTH   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  hpu_cmd_arbiter_if.slave  bus
);
  localparam int CW = cnt_width(MAX_OUTSTANDING);
  localparam int IW = idx_width(NUM_HPUS);

  typedef logic [IW-1:0] core_idx_t;
  typedef logic [CW-1:0] cnt_t;

  cnt_t [NUM_HPUS-1:0] cnt_q, cnt_d;
  core_idx_t           rr_q, gnt_idx;
  logic [NUM_HPUS-1:0] elig, req, gnt, resp_ok_vec;
  logic                gnt_vld, slot_free, resp_ok;
  logic                cmd_valid_q, cmd_valid_d, idle_q, idle_d, err_q;
  cmd_req_t            cmd_q, cmd_d;
  logic [NUM_HPUS-1:0] resp_vld_q;
  cmd_resp_t           resp_q;
  logic [CORE_ID_WIDTH-1:0] resp_core;

  assign resp_core = bus.cmd_resp_i.cmd_id.core_id;
  assign slot_free = !cmd_valid_q || bus.cmd_ready_i;
  assign req       = slot_free ? elig : '0;

  // Eligibility and completion matching use the registered count, so a
  // completion never frees a throttled core within the same cycle.
  for (genvar i = 0; i < NUM_HPUS; i++) begin : g_core
    logic inc, dec;
    assign elig[i]        = bus.hpu_cmd_valid_i[i] && (cnt_q[i] < cnt_t'(MAX_OUTSTANDING));
    assign dec            = bus.cmd_resp_valid_i && (resp_core == CORE_ID_WIDTH'(i))
                            && (cnt_q[i] != '0);
    assign resp_ok_vec[i] = dec;
    assign inc            = gnt_vld && (gnt_idx == core_idx_t'(i));
    assign cnt_d[i]       = (inc && !dec) ? cnt_q[i] + cnt_t'(1) :
                            (dec && !inc) ? cnt_q[i] - cnt_t'(1) : cnt_q[i];
  end

  hpu_rr_arb #(.N(NUM_HPUS), .IW(IW)) u_rr_arb (
    .req_i (req),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .vld_o (gnt_vld)
  );

  assign resp_ok     = |resp_ok_vec;
  assign cmd_d       = gnt_vld ? bus.hpu_cmd_i[gnt_idx] : cmd_q;
  assign cmd_valid_d = gnt_vld || (cmd_valid_q && !bus.cmd_ready_i);
  assign idle_d      = (cnt_d == '0) && !cmd_valid_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q       <= '0;
      rr_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= '0;
      resp_vld_q  <= '0;
      resp_q      <= '0;
      err_q       <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      cnt_q       <= cnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      if (gnt_vld) rr_q <= gnt_idx + core_idx_t'(1);
      resp_vld_q  <= resp_ok_vec;
      if (resp_ok) resp_q <= bus.cmd_resp_i;
      err_q       <= bus.cmd_resp_valid_i && !resp_ok;
      idle_q      <= idle_d;
    end
  end

  assign bus.hpu_cmd_ready_o      = gnt;
  assign bus.cmd_valid_o          = cmd_valid_q;
  assign bus.cmd_o                = cmd_q;
  assign bus.hpu_cmd_resp_valid_o = resp_vld_q;
  assign bus.hpu_cmd_resp_o       = resp_q;
  assign bus.resp_err_o           = err_q;
  assign bus.idle_o               = idle_q;
endmodule

// File: tb/tb_hpu_cmd_arbiter.sv
// Randomized bench for hpu_cmd_arbiter against a cycle-level behavioural
// model, plus a few hand-computed expectations from the directed scenarios.
module tb_hpu_cmd_arbiter;
  import hpu_cmd_pkg::*;

  localparam int N    = 8;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hpu_cmd_arbiter_if #(.NUM_HPUS(N)) bus();

  hpu_cmd_arbiter #(.NUM_HPUS(N), .MAX_OUTSTANDING(MAXO), .CORE_ID_WIDTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state: outstanding count per core, next-search pointer, output slot.
  int          m_cnt[N];
  int          m_rr   = 0;
  bit          m_vld  = 1'b0;
  cmd_req_t    m_cmd  = '0;
  logic [N-1:0] m_rvld = '0;
  cmd_resp_t   m_resp = '0;
  bit          m_err  = 1'b0;
  bit          m_idle = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] exp_grant();
    logic [N-1:0] g;
    g = '0;
    if (m_vld && !bus.cmd_ready_i) return g;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (bus.hpu_cmd_valid_i[i] && m_cnt[i] < MAXO) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic cmd_req_t mk_cmd(input int i);
    cmd_req_t c;
    c.cmd_id.cluster_id   = 8'h5a;
    c.cmd_id.core_id      = 16'(i);
    c.cmd_id.local_cmd_id = 8'($urandom);
    c.payload             = $urandom;
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      m_rr = 0; m_vld = 1'b0; m_cmd = '0; m_rvld = '0; m_resp = '0;
      m_err = 1'b0; m_idle = 1'b1;
    end else begin
      logic [N-1:0] g;
      int  c, gi;
      bit  ok, all0;
      g  = exp_grant();
      c  = int'(bus.cmd_resp_i.cmd_id.core_id);
      ok = bus.cmd_resp_valid_i && (c < N) && (m_cnt[c % N] > 0);
      gi = -1;
      for (int i = 0; i < N; i++) if (g[i]) gi = i;
      if (gi >= 0) begin
        m_cmd = bus.hpu_cmd_i[gi];
        m_vld = 1'b1;
        m_rr  = (gi + 1) % N;
        m_cnt[gi]++;
      end else if (bus.cmd_ready_i) begin
        m_vld = 1'b0;
      end
      m_rvld = '0;
      if (ok) begin
        m_cnt[c]--;
        m_rvld[c] = 1'b1;
        m_resp = bus.cmd_resp_i;
      end
      m_err = bus.cmd_resp_valid_i && !ok;
      all0 = 1'b1;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) all0 = 1'b0;
      m_idle = all0 && !m_vld;
    end
  end

  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("ready", 64'(bus.hpu_cmd_ready_o), 64'(exp_grant()));
      chk("cmd_valid", 64'(bus.cmd_valid_o), 64'(m_vld));
      if (m_vld) chk("cmd_o", 64'(bus.cmd_o), 64'(m_cmd));
      chk("resp_valid", 64'(bus.hpu_cmd_resp_valid_o), 64'(m_rvld));
      if (|m_rvld) chk("resp_o", 64'(bus.hpu_cmd_resp_o), 64'(m_resp));
      chk("resp_err", 64'(bus.resp_err_o), 64'(m_err));
      chk("idle", 64'(bus.idle_o), 64'(m_idle));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    bus.hpu_cmd_valid_i  = '0;
    bus.cmd_ready_i      = 1'b1;
    bus.cmd_resp_valid_i = 1'b0;
    bus.cmd_resp_i       = '0;
  endtask

  task automatic send_resp(input int core);
    bus.cmd_resp_valid_i           = 1'b1;
    bus.cmd_resp_i                 = '0;
    bus.cmd_resp_i.cmd_id.core_id  = 16'(core);
    bus.cmd_resp_i.status          = 8'($urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, 64'(bus.cmd_valid_o), 64'd0);
    chk({tag, "_cmd_o"}, 64'(bus.cmd_o), 64'd0);
    chk({tag, "_resp_valid"}, 64'(bus.hpu_cmd_resp_valid_o), 64'd0);
    chk({tag, "_resp_o"}, 64'(bus.hpu_cmd_resp_o), 64'd0);
    chk({tag, "_err"}, 64'(bus.resp_err_o), 64'd0);
    chk({tag, "_idle"}, 64'(bus.idle_o), 64'd1);
  endtask

  task automatic rand_cycle();
    for (int i = 0; i < N; i++) begin
      bus.hpu_cmd_valid_i[i] = 1'($urandom_range(0, 1));
      bus.hpu_cmd_i[i]       = mk_cmd(i);
    end
    bus.cmd_ready_i = ($urandom_range(0, 9) < 7);
    if ($urandom_range(0, 9) < 4)
      send_resp(($urandom_range(0, 9) < 9) ? int'($urandom_range(0, N - 1))
                                           : int'($urandom_range(N, 20)));
    else
      bus.cmd_resp_valid_i = 1'b0;
  endtask

  initial begin
    quiet();
    for (int i = 0; i < N; i++) bus.hpu_cmd_i[i] = mk_cmd(i);
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    chk_en = 1'b1;

    // Single core 3 with an empty arbiter.
    bus.hpu_cmd_valid_i[3] = 1'b1;
    #1 chk("single_ready", 64'(bus.hpu_cmd_ready_o), 64'h08);
    step();
    bus.hpu_cmd_valid_i = '0;
    #1;
    chk("single_cmd_valid", 64'(bus.cmd_valid_o), 64'd1);
    chk("single_core_id", 64'(bus.cmd_o.cmd_id.core_id), 64'd3);
    chk("single_idle", 64'(bus.idle_o), 64'd0);
    step();
    send_resp(3);
    step();
    bus.cmd_resp_valid_i = 1'b0;
    #1 chk("route_core3", 64'(bus.hpu_cmd_resp_valid_o), 64'h08);

    // Unroutable completion.
    send_resp(9);
    step();
    bus.cmd_resp_valid_i = 1'b0;
    #1;
    chk("err_pulse", 64'(bus.resp_err_o), 64'd1);
    chk("err_no_valid", 64'(bus.hpu_cmd_resp_valid_o), 64'd0);
    step();
    chk("err_single_cycle", 64'(bus.resp_err_o), 64'd0);

    // Throttle core 1 at MAXO outstanding.
    bus.hpu_cmd_valid_i[1] = 1'b1;
    repeat (MAXO) step();
    chk("throttle_stall", 64'(bus.hpu_cmd_ready_o), 64'd0);
    step();
    chk("throttle_hold", 64'(bus.hpu_cmd_ready_o), 64'd0);
    send_resp(1);
    #1 chk("throttle_same_cycle", 64'(bus.hpu_cmd_ready_o), 64'd0);
    step();
    bus.cmd_resp_valid_i = 1'b0;
    bus.hpu_cmd_valid_i  = '0;
    #1;
    chk("throttle_resp", 64'(bus.hpu_cmd_resp_valid_o), 64'h02);
    bus.hpu_cmd_valid_i[1] = 1'b1;
    #1 chk("throttle_regrant", 64'(bus.hpu_cmd_ready_o), 64'h02);
    bus.hpu_cmd_valid_i = '0;
    for (int k = 0; k < MAXO; k++) begin
      send_resp(1);
      step();
    end
    bus.cmd_resp_valid_i = 1'b0;

    // Fairness sweep with every core requesting.
    bus.hpu_cmd_valid_i = '1;
    repeat (10) step();
    bus.hpu_cmd_valid_i = '0;

    // Backpressure with core 2 holding a second command.
    bus.cmd_ready_i = 1'b0;
    bus.hpu_cmd_valid_i[2] = 1'b1;
    repeat (5) step();
    bus.cmd_ready_i = 1'b1;
    step();
    bus.hpu_cmd_valid_i = '0;
    step();

    // Random traffic with an asynchronous reset landing mid-flight.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_cycle();
      step();
      if (cyc == 1500) begin
        #3 rst = 1'b1;
        #1 check_reset_outputs("async_rst");
        step();
        rst = 1'b0;
      end
    end

    quiet();
    repeat (4) step();
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
